preemptive_clock_generator: RTL

- Synthesises the preemptive (local) clock that stands in for the tracked incoming clock.
- Consumes the drift handshake from drift_accumulator (pos/neg drift ready, drift accepted). Applies each accepted drift as a one-sys-cycle stretch or shrink of the next half-period.
- Enforces a configurable minimum number of generated edges between applications.
- Sits downstream of drift_tracking; feeds the edge-recovery logic.

---
 rtl/clks_alot_pkg.sv | 29 ++
 rtl/half_period_counter.sv | 46 ++++
 rtl/preemptive_clock_generator.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/clks_alot_pkg.sv
// Shared types and constants for the clock-recovery slice: clock-domain bundle,
// generator FSM states and the one-cycle drift adjustment encoding.
package clks_alot_pkg;

  typedef struct packed {
    logic clk;
    logic sync_rst;
  } sys_dom_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } pcg_state_t;

  typedef logic signed [1:0] drift_adj_t;

  localparam int unsigned MIN_HALF_PERIOD = 2;

  localparam drift_adj_t ADJ_ZERO = 2'sd0;
  localparam drift_adj_t ADJ_POS  = 2'sd1;
  localparam drift_adj_t ADJ_NEG  = -2'sd1;

  // Direction of an accepted drift, given which ready won arbitration.
  function automatic drift_adj_t drift_dir(input logic pos_wins);
    return pos_wins ? ADJ_POS : ADJ_NEG;
  endfunction

endpackage

// File: rtl/half_period_counter.sv
// Half-period timer for the preemptive clock: counts sys cycles, holds the
// one-shot drift adjustment and flags when the current half-period has elapsed.
module half_period_counter
  import clks_alot_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH = 16
) (
  input  sys_dom_t                 sys_dom_i,
  input  logic                     restart,
  input  logic                     count_en,
  input  logic                     adj_we,
  input  drift_adj_t               adj_d,
  input  logic [COUNTER_WIDTH-1:0] half_period,
  output logic                     limit_hit
);

  logic [COUNTER_WIDTH-1:0] hp_cnt;
  logic [COUNTER_WIDTH-1:0] limit;
  logic [COUNTER_WIDTH-1:0] adj_ext;
  drift_adj_t               adj_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge sys_dom_i.clk) begin
    if (sys_dom_i.sync_rst) begin
      hp_cnt <= '0;
      adj_q  <= ADJ_ZERO;
    end else begin
      if (restart) begin
        hp_cnt <= '0;
      end else if (count_en) begin
        hp_cnt <= hp_cnt + COUNTER_WIDTH'(1);
      end
      if (adj_we) begin
        adj_q <= adj_d;
      end
    end
  end

  assign adj_ext = {{(COUNTER_WIDTH-2){adj_q[1]}}, adj_q};
  assign limit   = half_period - COUNTER_WIDTH'(1) + adj_ext;

  // Magnitude compare so a live half_period change never lets the count run past.
  assign limit_hit = (hp_cnt >= limit);

endmodule

// File: rtl/preemptive_clock_generator.sv
// Local stand-in clock for the tracked input: toggles every half-period, applies
// accepted drifts as one-cycle stretch/shrink. Define DRIFT_STATS_EN for drift counters.
module preemptive_clock_generator
  import clks_alot_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH = 16,
  parameter int unsigned SPACING_WIDTH = 8
) (
  input  sys_dom_t                 sys_dom_i,
  input  logic                     enable_i,
  input  logic [COUNTER_WIDTH-1:0] half_period_i,
  input  logic [SPACING_WIDTH-1:0] min_edge_spacing_i,
  input  logic                     sync_i,
  input  logic                     pos_drift_ready_i,
  input  logic                     neg_drift_ready_i,
  output logic                     drift_accepted_o,
  output logic                     clk_o,
  output logic                     rise_edge_o,
  output logic                     fall_edge_o,
  output logic                     any_edge_o,
  output logic                     config_violation_o,
  output logic [15:0]              pos_drift_count_o,
  output logic [15:0]              neg_drift_count_o
);

  localparam logic [COUNTER_WIDTH-1:0] HP_MIN = COUNTER_WIDTH'(MIN_HALF_PERIOD);

  pcg_state_t               state_q;
  pcg_state_t               state_d;
  logic [SPACING_WIDTH-1:0] spacing_cnt;

  logic       hp_ok;
  logic       eligible;
  logic       want_pos;
  logic       want_neg;
  logic       accept;
  logic       limit_hit;
  logic       eval;
  logic       clk_d;
  logic       rise_d;
  logic       fall_d;
  logic       cnt_restart;
  logic       cnt_en;
  logic       adj_clear;
  logic       spacing_clear;
  logic       adj_we;
  drift_adj_t adj_d;

  assign hp_ok    = (half_period_i >= HP_MIN);
  assign eligible = (spacing_cnt >= min_edge_spacing_i);
  assign want_pos = pos_drift_ready_i & ~neg_drift_ready_i;
  // A shrink is refused when it would take the half-period below the minimum.
  assign want_neg = neg_drift_ready_i & ~pos_drift_ready_i & (half_period_i > HP_MIN);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    clk_d         = clk_o;
    rise_d        = 1'b0;
    fall_d        = 1'b0;
    eval          = 1'b0;
    cnt_restart   = 1'b0;
    cnt_en        = 1'b0;
    adj_clear     = 1'b0;
    spacing_clear = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable_i) begin
          if (hp_ok) begin
            state_d     = RUN;
            clk_d       = 1'b1;
            rise_d      = 1'b1;
            eval        = 1'b1;
            cnt_restart = 1'b1;
          end else begin
            state_d = HOLD;
          end
        end
      end
      RUN: begin
        if (!enable_i) begin
          state_d       = IDLE;
          clk_d         = 1'b0;
          fall_d        = clk_o;
          cnt_restart   = 1'b1;
          adj_clear     = 1'b1;
          spacing_clear = 1'b1;
        end else if (!hp_ok) begin
          state_d = HOLD;
        end else if (sync_i) begin
          cnt_restart = 1'b1;
          if (!clk_o) begin
            clk_d  = 1'b1;
            rise_d = 1'b1;
            eval   = 1'b1;
          end else begin
            adj_clear = 1'b1;
          end
        end else if (limit_hit) begin
          clk_d       = ~clk_o;
          rise_d      = ~clk_o;
          fall_d      = clk_o;
          eval        = 1'b1;
          cnt_restart = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      HOLD: begin
        if (!enable_i) begin
          state_d       = IDLE;
          clk_d         = 1'b0;
          fall_d        = clk_o;
          cnt_restart   = 1'b1;
          adj_clear     = 1'b1;
          spacing_clear = 1'b1;
        end else if (hp_ok) begin
          state_d     = RUN;
          cnt_restart = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    accept = eval & eligible & (want_pos | want_neg);
    adj_we = eval | adj_clear;
    adj_d  = accept ? drift_dir(want_pos) : ADJ_ZERO;
  end

  always_ff @(posedge sys_dom_i.clk) begin
    if (sys_dom_i.sync_rst) begin
      state_q            <= IDLE;
      spacing_cnt        <= '0;
      clk_o              <= 1'b0;
      rise_edge_o        <= 1'b0;
      fall_edge_o        <= 1'b0;
      any_edge_o         <= 1'b0;
      drift_accepted_o   <= 1'b0;
      config_violation_o <= 1'b0;
    end else begin
      state_q            <= state_d;
      clk_o              <= clk_d;
      rise_edge_o        <= rise_d;
      fall_edge_o        <= fall_d;
      any_edge_o         <= rise_d | fall_d;
      drift_accepted_o   <= accept;
      config_violation_o <= (state_d == HOLD);
      if (spacing_clear || accept) begin
        spacing_cnt <= '0;
      end else if (eval && (spacing_cnt != '1)) begin
        spacing_cnt <= spacing_cnt + SPACING_WIDTH'(1);
      end
    end
  end

  half_period_counter #(
    .COUNTER_WIDTH(COUNTER_WIDTH)
  ) u_half_period_counter (
    .sys_dom_i  (sys_dom_i),
    .restart    (cnt_restart),
    .count_en   (cnt_en),
    .adj_we     (adj_we),
    .adj_d      (adj_d),
    .half_period(half_period_i),
    .limit_hit  (limit_hit)
  );

`ifdef DRIFT_STATS_EN
  always_ff @(posedge sys_dom_i.clk) begin
    if (sys_dom_i.sync_rst) begin
      pos_drift_count_o <= '0;
      neg_drift_count_o <= '0;
    end else if (accept) begin
      if (want_pos && (pos_drift_count_o != 16'hFFFF)) begin
        pos_drift_count_o <= pos_drift_count_o + 16'd1;
      end
      if (want_neg && (neg_drift_count_o != 16'hFFFF)) begin
        neg_drift_count_o <= neg_drift_count_o + 16'd1;
      end
    end
  end
`else
  assign pos_drift_count_o = '0;
  assign neg_drift_count_o = '0;
`endif

endmodule
